ui_scanner: RTL
===============

UI_SCANNER -- requirements
Module: ui_scanner

Interface
REQ-001 Parameter DATA_W, default 32: width of each source data word and of lcd_data.
REQ-002 Parameter RD_LAT, default 1, legal 1..4: read latency in cycles from the index outputs to valid source data.
REQ-003 Parameter SCAN_DIV, default 25000000, legal >= RD_LAT+2: cycles per auto-scan step.
REQ-004 Parameter STRIDE, default 4: byte stride used to convert a word index to a displayed address.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-007 SW  in  18  board switches: [4:0] reg index, [9:5] ram index, [14:10] rom index, [16:15] source select, [17] scan enable.
REQ-008 clock_counter  in  16  free-running processor cycle count.
REQ-009 pc  in  16  processor program counter.
REQ-010 reg_out, ram_out, rom_out  in  DATA_W each  read data for reg_idx, ram_idx and rom_idx respectively.
REQ-011 reg_idx, ram_idx, rom_idx  out  5 each  word index issued to the register file, data RAM and instruction ROM.
REQ-012 lcd_data  out  DATA_W  captured word for the LCD.
REQ-013 lcd_upd  out  1  one-cycle pulse when lcd_data, digit7 and digit6 are updated.
REQ-014 digit7..digit0  out  4 each  hex digit nibbles.

Function
REQ-015 Source decode: SW[16:15]=00 register, 01 RAM, 10 or 11 ROM.
REQ-016 FSM states: ISSUE, WAIT, CAPTURE; reset state ISSUE.
REQ-017 ISSUE: latch source (sel_q) and index (idx_q) into a snapshot; drive idx_q on the selected source's index output; go to WAIT with wait counter = 0.
REQ-018 Index outputs of non-selected sources hold their previous values.
REQ-019 WAIT: increment wait counter each cycle; go to CAPTURE when counter reaches RD_LAT-1.
REQ-020 CAPTURE: lcd_data <= data of sel_q; {digit7,digit6} <= low 8 bits of idx_q*STRIDE; lcd_upd = 1 for this cycle only; go to ISSUE.
REQ-021 Refresh period is exactly RD_LAT+2 cycles; lcd_data and address digits always come from the same snapshot.
REQ-022 SW changes after ISSUE do not affect the refresh in flight; they take effect at the next ISSUE.
REQ-023 Manual mode (SW[17]=0): idx_q = switch field of the selected source.
REQ-024 Scan mode (SW[17]=1): idx_q = scan_idx, a 5-bit counter.
REQ-025 Scan divider counts 0..SCAN_DIV-1 continuously while SW[17]=1; on terminal count scan_idx increments, wrapping 31 -> 0; divider held at 0 while SW[17]=0.
REQ-026 Scan entry: on the cycle SW[17] is sampled 0 -> 1, scan_idx loads the switch field of the current source and divider clears.
REQ-027 Source change while in scan mode does not reload scan_idx.
REQ-028 digit5 <= pc[7:4], digit4 <= pc[3:0], digit3..digit0 <= clock_counter[15:12],[11:8],[7:4],[3:0]; updated every cycle, 1-cycle latency, independent of the FSM.
REQ-029 Address arithmetic: idx_q*STRIDE computed at 13 bits minimum, only bits [7:0] displayed (wraps silently).

Reset
REQ-030 While reset=0 at a clock edge: FSM -> ISSUE, wait counter, divider, scan_idx, sel_q, idx_q, all index outputs, lcd_data, lcd_upd and all digits -> 0.
REQ-031 Reset asserted mid-WAIT aborts the refresh; no lcd_upd pulse and no capture occur.
REQ-032 First ISSUE occurs on the first clock edge with reset=1.

Verification
REQ-033 Reset, SW=0x00000, reg_out=0xDEADBEEF, RD_LAT=1 -> lcd_upd first pulses 3 cycles after release, lcd_data=0xDEADBEEF, digit7/6=0/0.
REQ-034 SW[16:15]=01, SW[9:5]=7, ram_out=0x12345678 -> ram_idx=7, lcd_data=0x12345678, digit7/6=1/C.
REQ-035 SW[17]=1 with SW[14:10]=31, SW[16:15]=10, SCAN_DIV=8 -> rom_idx 31 then 0 after 8 cycles; digit7/6 = 7/C then 0/0.
REQ-036 RD_LAT=3, change SW[4:0] from 2 to 5 during WAIT -> capture shows index 2 (digits 0/8); next refresh shows 5 (1/4); lcd_upd period 5 cycles.
REQ-037 pc=0x00A4, clock_counter=0xBEEF -> digit5..0 = A,4,B,E,E,F one cycle later.
REQ-038 reset=0 during WAIT -> all outputs 0 next edge, no lcd_upd pulse.

Source files
------------

// File: rtl/ui_scanner.sv
// ---------------------------------------------------------------------------
// ui_scanner
//
// Display scanner for a small processor board. Each refresh snapshots one
// word from the register file, data RAM or instruction ROM (chosen by the
// switches), waits for the read latency and then captures the word for the
// LCD together with its byte address on digit7/digit6. The index comes
// either from the switches (manual mode) or from an auto-incrementing scan
// counter (scan mode). digit5..digit0 mirror pc and clock_counter.
//
// Ports
//   clk                        rising-edge clock
//   reset                      synchronous, active-low reset
//   SW[17:0]                   [4:0] reg idx, [9:5] ram idx, [14:10] rom idx,
//                              [16:15] source select, [17] scan enable
//   clock_counter[15:0]        free-running processor cycle count
//   pc[15:0]                   processor program counter
//   reg_out/ram_out/rom_out    read data for reg_idx/ram_idx/rom_idx
//   reg_idx/ram_idx/rom_idx    word index issued to each source
//   lcd_data                   captured word for the LCD
//   lcd_upd                    one-cycle pulse when lcd_data/digit7/digit6 update
//   digit7..digit0             hex digit nibbles
// ---------------------------------------------------------------------------
module ui_scanner #(
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int SCAN_DIV = 25000000,
    parameter int STRIDE   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [17:0]       SW,
    input  logic [15:0]       clock_counter,
    input  logic [15:0]       pc,
    input  logic [DATA_W-1:0] reg_out,
    input  logic [DATA_W-1:0] ram_out,
    input  logic [DATA_W-1:0] rom_out,
    output logic [4:0]        reg_idx,
    output logic [4:0]        ram_idx,
    output logic [4:0]        rom_idx,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_upd,
    output logic [3:0]        digit7,
    output logic [3:0]        digit6,
    output logic [3:0]        digit5,
    output logic [3:0]        digit4,
    output logic [3:0]        digit3,
    output logic [3:0]        digit2,
    output logic [3:0]        digit1,
    output logic [3:0]        digit0
);

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_CAPTURE} state_t;
    typedef enum logic [1:0] {SRC_REG, SRC_RAM, SRC_ROM} src_t;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 1);

    state_t           state_q, state_d;
    logic [1:0]       wait_cnt;
    logic             wait_done;
    logic             do_issue, do_capture;

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       scan_idx;
    logic             scan_en_q;
    logic             scan_enter;

    src_t             sel_now, sel_q;
    logic [4:0]       field_now, idx_now, idx_q;
    logic [7:0]       addr_lo;

    // ------------------------------------------------------------------
    // Source decode and index selection for the next snapshot
    // ------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        sel_now   = SRC_ROM;
        field_now = SW[14:10];
        case (SW[16:15])
            2'b00: begin
                sel_now   = SRC_REG;
                field_now = SW[4:0];
            end
            2'b01: begin
                sel_now   = SRC_RAM;
                field_now = SW[9:5];
            end
            default: begin
                sel_now   = SRC_ROM;
                field_now = SW[14:10];
            end
        endcase
    end

    // On the scan-entry cycle scan_idx is only just being loaded, so an
    // ISSUE landing on that same edge takes the switch field directly.
    assign scan_enter = SW[17] & ~scan_en_q;
    assign idx_now    = (SW[17] && !scan_enter) ? scan_idx : field_now;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_ISSUE;
        else        state_q <= state_d;
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT:    if (wait_done) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_ISSUE;
            default:    state_d = ST_ISSUE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        do_issue   = 1'b0;
        do_capture = 1'b0;
        case (state_q)
            ST_ISSUE:   do_issue   = 1'b1;
            ST_CAPTURE: do_capture = 1'b1;
            default:    ;
        endcase
    end

    assign wait_done = (wait_cnt == WAIT_LAST);

    // Wait counter: cleared on ISSUE, counts RD_LAT cycles in WAIT.
    always_ff @(posedge clk) begin
        if (!reset)                     wait_cnt <= '0;
        else if (do_issue)              wait_cnt <= '0;
        else if (state_q == ST_WAIT)    wait_cnt <= wait_cnt + 2'd1;
    end

    // ------------------------------------------------------------------
    // Scan divider and scan index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt   <= '0;
            scan_idx  <= '0;
            scan_en_q <= 1'b0;
        end else begin
            scan_en_q <= SW[17];
            if (scan_enter) begin
                div_cnt  <= '0;
                scan_idx <= field_now;
            end else if (SW[17]) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt  <= '0;
                    scan_idx <= scan_idx + 5'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot, index outputs and capture
    // ------------------------------------------------------------------
    // Address is formed at full integer width before keeping the low byte,
    // so large STRIDE values wrap rather than overflow a narrow product.
    assign addr_lo = 8'(32'(idx_q) * 32'(STRIDE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q    <= SRC_REG;
            idx_q    <= '0;
            reg_idx  <= '0;
            ram_idx  <= '0;
            rom_idx  <= '0;
            lcd_data <= '0;
            lcd_upd  <= 1'b0;
            digit7   <= '0;
            digit6   <= '0;
        end else begin
            lcd_upd <= do_capture;
            if (do_issue) begin
                sel_q <= sel_now;
                idx_q <= idx_now;
                // Non-selected index outputs hold their last value.
                case (sel_now)
                    SRC_REG: reg_idx <= idx_now;
                    SRC_RAM: ram_idx <= idx_now;
                    default: rom_idx <= idx_now;
                endcase
            end
            if (do_capture) begin
                case (sel_q)
                    SRC_REG: lcd_data <= reg_out;
                    SRC_RAM: lcd_data <= ram_out;
                    default: lcd_data <= rom_out;
                endcase
                digit7 <= addr_lo[7:4];
                digit6 <= addr_lo[3:0];
            end
        end
    end

    // Status digits track pc and clock_counter every cycle.
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc[15:8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            digit5 <= '0;
            digit4 <= '0;
            digit3 <= '0;
            digit2 <= '0;
            digit1 <= '0;
            digit0 <= '0;
        end else begin
            digit5 <= pc[7:4];
            digit4 <= pc[3:0];
            digit3 <= clock_counter[15:12];
            digit2 <= clock_counter[11:8];
            digit1 <= clock_counter[7:4];
            digit0 <= clock_counter[3:0];
        end
    end

endmodule
